// File: rtl/pwm_bank_pkg.sv
// Shared elaboration helpers and types for the PWM bank.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package pwm_bank_pkg;

   localparam int DUTY_W_DEFAULT = 11;

   typedef logic [DUTY_W_DEFAULT-1:0] duty_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } pend_state_t;

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; (1 << i) < v; i++) begin
         r = i + 1;
      end
      return r;
   endfunction

   // PWM period in ticks for a given duty width: all-ones duty means always high.
   function automatic int period(input int dw);
      return (1 << dw) - 1;
   endfunction

endpackage

// File: rtl/pwm_cmp_cell.sv
// One PWM channel: phase-shifted counter position compared against the live duty.
// Latency: output registered on the tick edge where the counter takes the compared value.
// Backpressure: none; free-running on tick.
module pwm_cmp_cell
   import pwm_bank_pkg::*;
#(
   parameter int OFFSET = 0,
   parameter int DUTY_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [DUTY_W-1:0] cnt_nxt,
   input  logic              stag_nxt,
   input  logic [DUTY_W-1:0] duty_nxt,
   output logic              pwm
);
   localparam int PERIOD = period(DUTY_W);

   logic [DUTY_W:0]   sum;
   logic [DUTY_W-1:0] pos;

   // Phase-shifted position; OFFSET < PERIOD so a single conditional subtract wraps it.
   always_comb begin
      sum = {1'b0, cnt_nxt} + (DUTY_W+1)'(OFFSET);
      if (sum >= (DUTY_W+1)'(PERIOD)) begin
         sum = sum - (DUTY_W+1)'(PERIOD);
      end
      pos = stag_nxt ? sum[DUTY_W-1:0] : cnt_nxt;
   end

   // Compare against the value the counter, duty and mode take on this edge, so pwm stays aligned with cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else if (tick) begin
         pwm <= (pos < duty_nxt);
      end
   end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// Multi-channel PWM engine with shadow duty bank committed atomically at the period wrap.
// Latency: write lands in shadow next clk; commit goes live at the next period wrap.
// Backpressure: wr_ready low while a commit is pending, so a committed frame cannot be altered.
module pwm_bank_ctrl
   import pwm_bank_pkg::*;
#(
   parameter  int CH_COUNT     = 64,
   parameter  int DUTY_W       = 11,
   parameter  int PRESCALE     = 1,
   parameter  int STAGGER_STEP = 32,
   localparam int ADDR_W       = clog2(CH_COUNT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DUTY_W-1:0]   wr_data,
   output logic                wr_err,
   input  logic                commit,
   input  logic                stagger_en,
   output logic                pending,
   output logic                period_start,
   output logic [CH_COUNT-1:0] pwm_out
);
   localparam int PERIOD = period(DUTY_W);
   localparam int PS_W   = clog2(PRESCALE + 1);

   typedef logic [DUTY_W-1:0] cell_duty_t;

   logic [PS_W-1:0]   ps_q;
   logic [DUTY_W-1:0] cnt_q;
   logic [DUTY_W-1:0] cnt_nxt;
   logic              tick;
   logic              wrap;
   logic              load;
   logic              rdy_q;
   logic              stag_q;
   logic              stag_nxt;
   logic              wr_fire;
   logic              addr_ok;
   cell_duty_t        shadow_q [CH_COUNT];
   cell_duty_t        active_q [CH_COUNT];
   pend_state_t       state_q;
   pend_state_t       state_d;

   assign tick     = (ps_q == PS_W'(PRESCALE - 1));
   assign wrap     = tick && (cnt_q == DUTY_W'(PERIOD - 1));
   assign cnt_nxt  = wrap ? '0 : cnt_q + DUTY_W'(1);
   assign pending  = (state_q == ST_PENDING);
   assign load     = wrap && pending;
   assign stag_nxt = wrap ? stagger_en : stag_q;
   assign wr_ready = rdy_q && !pending;
   assign wr_fire  = wr_valid && wr_ready;
   assign addr_ok  = (int'(wr_addr) < CH_COUNT);

   // Prescaler and period counter; cnt only moves on a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_q  <= '0;
         cnt_q <= '0;
      end else begin
         ps_q <= tick ? '0 : ps_q + PS_W'(1);
         if (tick) begin
            cnt_q <= cnt_nxt;
         end
      end
   end

   // Registered status pulses, ready enable and the stagger mode latched only at the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q        <= 1'b0;
         period_start <= 1'b0;
         wr_err       <= 1'b0;
         stag_q       <= 1'b0;
      end else begin
         rdy_q        <= 1'b1;
         period_start <= wrap;
         wr_err       <= wr_fire && !addr_ok;
         stag_q       <= stag_nxt;
      end
   end

   // Pending state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit arms the pending state; the wrap applies it. A commit while pending is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (commit) state_d = ST_PENDING;
         ST_PENDING: if (wrap)   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Shadow bank; out-of-range addresses are dropped and flagged on wr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CH_COUNT; k++) begin
            shadow_q[k] <= '0;
         end
      end else if (wr_fire && addr_ok) begin
         shadow_q[wr_addr] <= wr_data;
      end
   end

   // Active bank copied whole from shadow at the wrap that ends a pending commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CH_COUNT; k++) begin
            active_q[k] <= '0;
         end
      end else if (load) begin
         for (int k = 0; k < CH_COUNT; k++) begin
            active_q[k] <= shadow_q[k];
         end
      end
   end

   for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
      pwm_cmp_cell #(
         .OFFSET ((k * STAGGER_STEP) % PERIOD),
         .DUTY_W (DUTY_W)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .cnt_nxt  (cnt_nxt),
         .stag_nxt (stag_nxt),
         .duty_nxt (load ? shadow_q[k] : active_q[k]),
         .pwm      (pwm_out[k])
      );
   end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Bench for pwm_bank_ctrl: behavioural frame model plus directed and random stimulus.
// Latency: n/a.
// Backpressure: stimulus holds wr_valid until wr_ready.
module tb_pwm_bank_ctrl;
   localparam int CH = 4;
   localparam int DW = 4;
   localparam int PS = 2;
   localparam int SS = 3;
   localparam int P  = 15;
   localparam int FR = PS * P;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [1:0]    wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_err;
   logic          commit = 1'b0;
   logic          stagger_en = 1'b0;
   logic          pending;
   logic          period_start;
   logic [CH-1:0] pwm_out;

   logic          b_wr_valid = 1'b0;
   logic          b_wr_ready;
   logic [1:0]    b_wr_addr = '0;
   logic [DW-1:0] b_wr_data = '0;
   logic          b_wr_err;
   logic          b_commit = 1'b0;
   logic          b_stagger_en = 1'b0;
   logic          b_pending;
   logic          b_period_start;
   logic [2:0]    b_pwm_out;

   int checks = 0;
   int errors = 0;
   int hi [CH];

   always #5 clk = ~clk;

   pwm_bank_ctrl #(.CH_COUNT(CH), .DUTY_W(DW), .PRESCALE(PS), .STAGGER_STEP(SS)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .commit(commit), .stagger_en(stagger_en),
      .pending(pending), .period_start(period_start), .pwm_out(pwm_out));

   pwm_bank_ctrl #(.CH_COUNT(3), .DUTY_W(DW), .PRESCALE(PS), .STAGGER_STEP(SS)) dut_b (
      .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .wr_err(b_wr_err), .commit(b_commit), .stagger_en(b_stagger_en),
      .pending(b_pending), .period_start(b_period_start), .pwm_out(b_pwm_out));

   // Behavioural model: m_n counts clocks since reset; frames are FR clocks long.
   int            m_n;
   logic          m_pend, m_rdy, m_err, m_ps, m_stag;
   logic [DW-1:0] m_shadow [CH];
   logic [DW-1:0] m_active [CH];

   function automatic bit is_wrap(input int n);
      return (n % FR) == FR - 1;
   endfunction

   function automatic logic [CH-1:0] exp_pwm();
      logic [CH-1:0] r;
      int c, s;
      c = (m_n / PS) % P;
      for (int k = 0; k < CH; k++) begin
         s = m_stag ? (c + (k * SS) % P) % P : c;
         r[k] = (s < int'(m_active[k]));
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n <= 0; m_pend <= 1'b0; m_rdy <= 1'b0; m_err <= 1'b0; m_ps <= 1'b0; m_stag <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            m_shadow[k] <= '0;
            m_active[k] <= '0;
         end
      end else begin
         m_n   <= m_n + 1;
         m_rdy <= 1'b1;
         m_ps  <= is_wrap(m_n);
         m_err <= wr_valid && m_rdy && !m_pend && (int'(wr_addr) >= CH);
         if (wr_valid && m_rdy && !m_pend && int'(wr_addr) < CH) m_shadow[wr_addr] <= wr_data;
         if (is_wrap(m_n)) begin
            m_stag <= stagger_en;
            if (m_pend) begin
               for (int k = 0; k < CH; k++) m_active[k] <= m_shadow[k];
            end
         end
         if (m_pend) begin
            if (is_wrap(m_n)) m_pend <= 1'b0;
         end else if (commit) begin
            m_pend <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm()));
      check("wr_ready", 32'(wr_ready), 32'(m_rdy && !m_pend));
      check("pending", 32'(pending), 32'(m_pend));
      check("period_start", 32'(period_start), 32'(m_ps));
      check("wr_err", 32'(wr_err), 32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      int b;
      b = 0;
      wr_valid = 1'b1; wr_addr = 2'(a); wr_data = DW'(d);
      while (!wr_ready && b < 100) begin step(); b++; end
      check("wr_timeout", 32'(b >= 100), 0);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1; step(); commit = 1'b0;
   endtask

   task automatic wait_applied(input string name);
      int b;
      b = 0;
      while (pending && b < 100) begin step(); b++; end
      check(name, 32'(b >= 100), 0);
   endtask

   task automatic wait_period(input string name);
      int b;
      b = 0;
      while (!period_start && b < 100) begin step(); b++; end
      check(name, 32'(b >= 100), 0);
   endtask

   task automatic measure();
      for (int k = 0; k < CH; k++) hi[k] = 0;
      for (int i = 0; i < FR; i++) begin
         for (int k = 0; k < CH; k++) if (pwm_out[k]) hi[k]++;
         step();
      end
   endtask

   initial begin
      int n;
      int bh [3];
      logic [14:0] mask [CH];

      // 1. reset and first period
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", 32'(pwm_out), 0);
      check("rst_ready", 32'(wr_ready), 0);
      rst = 1'b0;
      #1;
      check("ready_before_clk", 32'(wr_ready), 0);
      n = 0;
      while (!period_start && n < 40) begin
         step(); n++;
         if (n == 1) check("ready_first_clk", 32'(wr_ready), 1);
      end
      check("first_period_start", n, 30);

      // 2. duty levels
      wr(0, 0); wr(1, 5); wr(2, 15); wr(3, 7);
      pulse_commit();
      wait_applied("t2_apply_timeout");
      measure();
      check("duty0_hi", hi[0], 0);
      check("duty5_hi", hi[1], 10);
      check("duty15_hi", hi[2], 30);
      check("duty7_hi", hi[3], 14);

      // 3. back-pressure: write stalls until the pending commit is applied
      pulse_commit();
      check("bp_pending", 32'(pending), 1);
      wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'd12;
      n = 0;
      while (!wr_ready && n < 100) begin step(); n++; end
      check("bp_stall_clks", n, 29);
      check("bp_wrap_seen", 32'(period_start), 1);
      step();
      wr_valid = 1'b0;
      wait_period("t3_period_timeout");
      measure();
      check("bp_active_unchanged", hi[1], 10);
      pulse_commit();
      wait_applied("t3_apply_timeout");
      measure();
      check("bp_new_duty", hi[1], 24);

      // 4. commit + write on the wrap cycle, second commit while pending
      repeat (29) step();
      commit = 1'b1; wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 4'd3;
      step();
      commit = 1'b0; wr_valid = 1'b0;
      check("wrapcommit_pending", 32'(pending), 1);
      check("wrapcommit_wrap", 32'(period_start), 1);
      n = 0;
      while (pending && n < 100) begin
         step(); n++;
         commit = (n == 10);
      end
      commit = 1'b0;
      check("wrapcommit_delay", n, 30);
      measure();
      check("samecycle_write_live", hi[3], 6);

      // 5. stagger
      wr(0, 5); wr(1, 5); wr(2, 5); wr(3, 5);
      pulse_commit();
      wait_applied("t5_apply_timeout");
      repeat (10) step();
      stagger_en = 1'b1;
      n = 0;
      while (!period_start && n < 100) begin step(); n++; end
      check("stagger_wait", n, 20);
      for (int i = 0; i < FR; i++) begin
         if (i % 2 == 0) for (int k = 0; k < CH; k++) mask[k][i/2] = pwm_out[k];
         step();
      end
      check("stagger_ch0", 32'(mask[0]), 32'h001F);
      check("stagger_ch1", 32'(mask[1]), 32'h7003);
      check("stagger_ch2", 32'(mask[2]), 32'h3E00);
      check("stagger_ch3", 32'(mask[3]), 32'h07C0);

      // reset mid-period with a commit pending
      pulse_commit();
      repeat (2) step();
      #3 rst = 1'b1;
      #1;
      check("midrst_pwm", 32'(pwm_out), 0);
      check("midrst_ready", 32'(wr_ready), 0);
      check("midrst_pending", 32'(pending), 0);
      step();
      rst = 1'b0;

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         wr_valid = 1'($urandom % 2);
         wr_addr  = 2'($urandom % 4);
         wr_data  = DW'($urandom);
         commit   = ($urandom % 16) == 0;
         if ($urandom % 200 == 0) stagger_en = ~stagger_en;
         step();
      end
      wr_valid = 1'b0; commit = 1'b0;

      // 6. out-of-range address on a 3-channel bank
      check("b_ready0", 32'(b_wr_ready), 1);
      b_wr_valid = 1'b1; b_wr_addr = 2'd0; b_wr_data = 4'd9;
      step();
      b_wr_valid = 1'b0;
      check("b_err_goodaddr", 32'(b_wr_err), 0);
      b_commit = 1'b1; step(); b_commit = 1'b0;
      n = 0;
      while (b_pending && n < 100) begin step(); n++; end
      check("b_apply_timeout", 32'(n >= 100), 0);
      check("b_ready1", 32'(b_wr_ready), 1);
      b_wr_valid = 1'b1; b_wr_addr = 2'd3; b_wr_data = 4'd15;
      step();
      b_wr_valid = 1'b0;
      check("b_err_pulse", 32'(b_wr_err), 1);
      step();
      check("b_err_clear", 32'(b_wr_err), 0);
      b_commit = 1'b1; step(); b_commit = 1'b0;
      n = 0;
      while (b_pending && n < 100) begin step(); n++; end
      check("b_apply2_timeout", 32'(n >= 100), 0);
      for (int k = 0; k < 3; k++) bh[k] = 0;
      for (int i = 0; i < FR; i++) begin
         for (int k = 0; k < 3; k++) if (b_pwm_out[k]) bh[k]++;
         step();
      end
      check("b_ch0_hi", bh[0], 18);
      check("b_ch1_hi", bh[1], 0);
      check("b_ch2_hi", bh[2], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
